// File: rtl/time_set_sequencer_if.sv
// rtl/time_set_sequencer_if.sv - target, live-counter and advance-strobe bundle between sequencer and clock
// master: the sequencer side; slave: the clock or bench side that supplies targets and live counters.
interface time_set_sequencer_if;
  logic       Start;
  logic       Abort;
  logic [6:0] TgtMin;
  logic [6:0] TgtHrs;
  logic [6:0] TgtDay;
  logic [5:0] TgtDate;
  logic [3:0] TgtMonth;
  logic [6:0] CurMin;
  logic [6:0] CurHrs;
  logic [6:0] CurDay;
  logic [5:0] CurDate;
  logic [3:0] CurMonth;
  logic       Timeset;
  logic       Minadv;
  logic       Hrsadv;
  logic       Dayadv;
  logic       Datadv;
  logic       Monadv;
  logic       Busy;
  logic       Done;
  logic       Err;

  modport master (
    input  Start, Abort,
    input  TgtMin, TgtHrs, TgtDay, TgtDate, TgtMonth,
    input  CurMin, CurHrs, CurDay, CurDate, CurMonth,
    output Timeset, Minadv, Hrsadv, Dayadv, Datadv, Monadv,
    output Busy, Done, Err
  );

  modport slave (
    output Start, Abort,
    output TgtMin, TgtHrs, TgtDay, TgtDate, TgtMonth,
    output CurMin, CurHrs, CurDay, CurDate, CurMonth,
    input  Timeset, Minadv, Hrsadv, Dayadv, Datadv, Monadv,
    input  Busy, Done, Err
  );
endinterface

// File: rtl/time_set_sequencer.sv
// rtl/time_set_sequencer.sv - drives Timeset and advance strobes until the live clock matches a target
// Fields are set in the order date-to-1, month, date, weekday, hour, minute, always stepping forward.
module time_set_sequencer #(
  parameter int NS   = 60,
  parameter int NH   = 24,
  parameter int ND   = 7,
  parameter int NM   = 12,
  parameter int YEAR = 2024
) (
  input logic                  Pulse,
  input logic                  Reset,
  time_set_sequencer_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CHECK, S_ADV, S_DONE} state_t;
  typedef enum logic [2:0] {P_DATE1, P_MONTH, P_DATE, P_DAY, P_HRS, P_MIN} phase_t;

  localparam bit LEAP = ((YEAR % 4 == 0) && (YEAR % 100 != 0)) || (YEAR % 400 == 0);

  function automatic logic [5:0] max_days(input logic [3:0] month);
    case (month)
      4'd2:                    max_days = LEAP ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11: max_days = 6'd30;
      default:                 max_days = 6'd31;
    endcase
  endfunction

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] tgt_min_q, tgt_min_d;
  logic [6:0] tgt_hrs_q, tgt_hrs_d;
  logic [6:0] tgt_day_q, tgt_day_d;
  logic [5:0] tgt_date_q, tgt_date_d;
  logic [3:0] tgt_month_q, tgt_month_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       minadv_q, minadv_d;
  logic       hrsadv_q, hrsadv_d;
  logic       dayadv_q, dayadv_d;
  logic       datadv_q, datadv_d;
  logic       monadv_q, monadv_d;

  logic [6:0] cur_fld;
  logic [6:0] tgt_fld;
  logic [7:0] step_lim;
  logic       tgt_ok;
  logic       adv;

  // Field under test for the current phase; DATE1 always aims at the 1st of the month.
  always_comb begin
    cur_fld  = bus.CurMin;
    tgt_fld  = tgt_min_q;
    step_lim = 8'(NS);
    case (phase_q)
      P_DATE1: begin
        cur_fld  = {1'b0, bus.CurDate};
        tgt_fld  = 7'd1;
        step_lim = 8'd31;
      end
      P_MONTH: begin
        cur_fld  = {3'b000, bus.CurMonth};
        tgt_fld  = {3'b000, tgt_month_q};
        step_lim = 8'(NM);
      end
      P_DATE: begin
        cur_fld  = {1'b0, bus.CurDate};
        tgt_fld  = {1'b0, tgt_date_q};
        step_lim = 8'd31;
      end
      P_DAY: begin
        cur_fld  = bus.CurDay;
        tgt_fld  = tgt_day_q;
        step_lim = 8'(ND);
      end
      P_HRS: begin
        cur_fld  = bus.CurHrs;
        tgt_fld  = tgt_hrs_q;
        step_lim = 8'(NH);
      end
      default: begin
        cur_fld  = bus.CurMin;
        tgt_fld  = tgt_min_q;
        step_lim = 8'(NS);
      end
    endcase
  end

  always_comb begin
    tgt_ok = (int'(bus.TgtMin) < NS) && (int'(bus.TgtHrs) < NH) && (int'(bus.TgtDay) < ND)
          && (bus.TgtMonth != 4'd0) && (int'(bus.TgtMonth) <= NM)
          && (bus.TgtDate != 6'd0) && (bus.TgtDate <= max_days(bus.TgtMonth));
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    tgt_min_d   = tgt_min_q;
    tgt_hrs_d   = tgt_hrs_q;
    tgt_day_d   = tgt_day_q;
    tgt_date_d  = tgt_date_q;
    tgt_month_d = tgt_month_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Abort) begin
          tgt_min_d   = bus.TgtMin;
          tgt_hrs_d   = bus.TgtHrs;
          tgt_day_d   = bus.TgtDay;
          tgt_date_d  = bus.TgtDate;
          tgt_month_d = bus.TgtMonth;
          err_d       = !tgt_ok;
          if (tgt_ok) begin
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        state_d = S_CHECK;
        phase_d = P_DATE1;
        cnt_d   = '0;
      end
      S_CHECK: begin
        if (cur_fld == tgt_fld) begin
          cnt_d = '0;
          if (phase_q == P_MIN) begin
            state_d = S_DONE;
          end else begin
            phase_d = phase_t'(phase_q + 3'd1);
          end
        end else if (cnt_q >= step_lim) begin
          // The counter has not converged within one full lap: the clock is not following strobes.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ADV;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_ADV:   state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.Abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end
  end

  // Outputs are registered copies of a decode of the next state.
  always_comb begin
    adv      = (state_d == S_ADV);
    active_d = (state_d == S_ARM) || (state_d == S_CHECK) || (state_d == S_ADV);
    done_d   = (state_d == S_DONE);
    minadv_d = adv && (phase_d == P_MIN);
    hrsadv_d = adv && (phase_d == P_HRS);
    dayadv_d = adv && (phase_d == P_DAY);
    datadv_d = adv && ((phase_d == P_DATE1) || (phase_d == P_DATE));
    monadv_d = adv && (phase_d == P_MONTH);
  end

  always_ff @(posedge Pulse or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      phase_q     <= P_DATE1;
      cnt_q       <= '0;
      tgt_min_q   <= '0;
      tgt_hrs_q   <= '0;
      tgt_day_q   <= '0;
      tgt_date_q  <= '0;
      tgt_month_q <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      minadv_q    <= 1'b0;
      hrsadv_q    <= 1'b0;
      dayadv_q    <= 1'b0;
      datadv_q    <= 1'b0;
      monadv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      tgt_min_q   <= tgt_min_d;
      tgt_hrs_q   <= tgt_hrs_d;
      tgt_day_q   <= tgt_day_d;
      tgt_date_q  <= tgt_date_d;
      tgt_month_q <= tgt_month_d;
      active_q    <= active_d;
      done_q      <= done_d;
      err_q       <= err_d;
      minadv_q    <= minadv_d;
      hrsadv_q    <= hrsadv_d;
      dayadv_q    <= dayadv_d;
      datadv_q    <= datadv_d;
      monadv_q    <= monadv_d;
    end
  end

  assign bus.Timeset = active_q;
  assign bus.Busy    = active_q;
  assign bus.Done    = done_q;
  assign bus.Err     = err_q;
  assign bus.Minadv  = minadv_q;
  assign bus.Hrsadv  = hrsadv_q;
  assign bus.Dayadv  = dayadv_q;
  assign bus.Datadv  = datadv_q;
  assign bus.Monadv  = monadv_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// tb/tb_time_set_sequencer.sv - sequencer bench with a behavioural clock and arithmetic strobe-count model
module tb_time_set_sequencer;
  localparam int NS = 60, NH = 24, ND = 7, NM = 12, YEAR = 2024;

  logic Pulse = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;

  int c_min = 0, c_hrs = 0, c_day = 0, c_date = 1, c_mon = 1;
  bit stuck_hrs = 1'b0;
  int n_min = 0, n_hrs = 0, n_day = 0, n_date = 0, n_mon = 0, viol = 0;
  logic [4:0] prev_stb = '0;

  time_set_sequencer_if bus ();

  time_set_sequencer #(.NS(NS), .NH(NH), .ND(ND), .NM(NM), .YEAR(YEAR)) dut (
    .Pulse(Pulse),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Pulse = ~Pulse;

  assign bus.CurMin   = 7'(c_min);
  assign bus.CurHrs   = 7'(c_hrs);
  assign bus.CurDay   = 7'(c_day);
  assign bus.CurDate  = 6'(c_date);
  assign bus.CurMonth = 4'(c_mon);

  function automatic int mdays(int m);
    int leap;
    leap = (((YEAR % 4) == 0) && ((YEAR % 100) != 0)) || ((YEAR % 400) == 0);
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Clock top level: counters step on the edge that samples an advance strobe.
  always @(posedge Pulse) begin
    logic [4:0] s;
    s = {bus.Monadv, bus.Datadv, bus.Dayadv, bus.Hrsadv, bus.Minadv};
    if ($countones(s) > 1) viol++;
    if ((s != 5'd0) && (prev_stb != 5'd0)) viol++;
    prev_stb = s;
    if (bus.Minadv === 1'b1) begin n_min++; c_min = (c_min + 1) % NS; end
    if (bus.Hrsadv === 1'b1) begin n_hrs++; if (!stuck_hrs) c_hrs = (c_hrs + 1) % NH; end
    if (bus.Dayadv === 1'b1) begin n_day++; c_day = (c_day + 1) % ND; end
    if (bus.Datadv === 1'b1) begin n_date++; c_date = (c_date >= mdays(c_mon)) ? 1 : c_date + 1; end
    if (bus.Monadv === 1'b1) begin n_mon++; c_mon = (c_mon >= NM) ? 1 : c_mon + 1; end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_min = 0; n_hrs = 0; n_day = 0; n_date = 0; n_mon = 0; viol = 0;
  endtask

  task automatic set_clock(int mo, int da, int dy, int h, int mi);
    c_mon = mo; c_date = da; c_day = dy; c_hrs = h; c_min = mi;
  endtask

  task automatic drive_tgt(int mo, int da, int dy, int h, int mi);
    bus.TgtMonth = 4'(mo); bus.TgtDate = 6'(da); bus.TgtDay = 7'(dy);
    bus.TgtHrs = 7'(h); bus.TgtMin = 7'(mi);
  endtask

  task automatic do_start(int mo, int da, int dy, int h, int mi);
    @(negedge Pulse);
    drive_tgt(mo, da, dy, h, mi);
    bus.Start = 1'b1;
    @(negedge Pulse);
    bus.Start = 1'b0;
  endtask

  task automatic run_valid(string tag, int mo, int da, int dy, int h, int mi);
    int e_d1, e_mo, e_da, e_dy, e_h, e_mi, k, done_at;
    logic ts_at_done, busy_at_done;
    e_d1 = (c_date == 1) ? 0 : mdays(c_mon) - c_date + 1;
    e_mo = (mo - c_mon + NM) % NM;
    e_da = da - 1;
    e_dy = (dy - c_day + ND) % ND;
    e_h  = (h - c_hrs + NH) % NH;
    e_mi = (mi - c_min + NS) % NS;
    k = e_d1 + e_mo + e_da + e_dy + e_h + e_mi;
    clear_counts();
    do_start(mo, da, dy, h, mi);
    chk({tag, ":arm_timeset"}, bus.Timeset, 1);
    chk({tag, ":arm_err"}, bus.Err, 0);
    done_at = -1;
    ts_at_done = 1'b1;
    busy_at_done = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge Pulse);
      if (bus.Done === 1'b1) begin
        done_at = cyc;
        ts_at_done = bus.Timeset;
        busy_at_done = bus.Busy;
        break;
      end
    end
    chk({tag, ":done_edge"}, done_at, 7 + 2 * k);
    chk({tag, ":done_timeset"}, ts_at_done, 0);
    chk({tag, ":done_busy"}, busy_at_done, 0);
    chk({tag, ":n_monadv"}, n_mon, e_mo);
    chk({tag, ":n_datadv"}, n_date, e_d1 + e_da);
    chk({tag, ":n_dayadv"}, n_day, e_dy);
    chk({tag, ":n_hrsadv"}, n_hrs, e_h);
    chk({tag, ":n_minadv"}, n_min, e_mi);
    chk({tag, ":clock_matches"},
        (c_mon == mo) && (c_date == da) && (c_day == dy) && (c_hrs == h) && (c_min == mi), 1);
    chk({tag, ":err"}, bus.Err, 0);
    chk({tag, ":strobe_rules"}, viol, 0);
  endtask

  task automatic start_invalid(string tag, int mo, int da, int dy, int h, int mi);
    clear_counts();
    do_start(mo, da, dy, h, mi);
    chk({tag, ":err"}, bus.Err, 1);
    chk({tag, ":timeset"}, bus.Timeset, 0);
    chk({tag, ":busy"}, bus.Busy, 0);
    repeat (4) @(negedge Pulse);
    chk({tag, ":no_strobes"}, n_min + n_hrs + n_day + n_date + n_mon, 0);
    chk({tag, ":timeset_later"}, bus.Timeset, 0);
  endtask

  initial begin
    int mo, da, seen_done, seen_err, got;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    drive_tgt(1, 1, 0, 0, 0);

    repeat (2) @(negedge Pulse);
    chk("rst:timeset", bus.Timeset, 0);
    chk("rst:busy", bus.Busy, 0);
    chk("rst:done", bus.Done, 0);
    chk("rst:err", bus.Err, 0);
    chk("rst:strobes", {bus.Minadv, bus.Hrsadv, bus.Dayadv, bus.Datadv, bus.Monadv}, 0);
    Reset = 1'b0;

    set_clock(1, 1, 0, 0, 0);
    run_valid("mar15", 3, 15, 3, 13, 45);

    set_clock(1, 31, 0, 0, 0);
    run_valid("feb29", 2, 29, 0, 0, 0);

    start_invalid("min60", 1, 1, 0, 0, 60);

    // Abort beats Start in IDLE: Err must stay set and nothing starts.
    @(negedge Pulse);
    drive_tgt(1, 1, 0, 0, 1);
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    @(negedge Pulse);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    chk("abort_idle:err", bus.Err, 1);
    chk("abort_idle:busy", bus.Busy, 0);

    set_clock(6, 30, 2, 11, 30);
    run_valid("dec31", 12, 31, 6, 23, 59);

    start_invalid("feb30", 2, 30, 0, 0, 0);
    start_invalid("month13", 13, 1, 0, 0, 0);

    // Stuck hour counter trips the step guard after one full lap of strobes.
    set_clock(3, 15, 3, 5, 45);
    stuck_hrs = 1'b1;
    clear_counts();
    do_start(3, 15, 3, 6, 45);
    seen_done = 0;
    seen_err = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge Pulse);
      if (bus.Done === 1'b1) seen_done = 1;
      if (bus.Err === 1'b1) begin seen_err = 1; break; end
    end
    chk("stuck:err", seen_err, 1);
    chk("stuck:n_hrsadv", n_hrs, NH);
    chk("stuck:timeset", bus.Timeset, 0);
    chk("stuck:busy", bus.Busy, 0);
    chk("stuck:no_done", seen_done, 0);
    stuck_hrs = 1'b0;

    // Abort partway through the minute phase, then finish with a fresh Start.
    set_clock(1, 1, 0, 0, 0);
    clear_counts();
    do_start(1, 1, 0, 0, 30);
    got = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (n_min == 10) begin got = 1; break; end
      @(negedge Pulse);
    end
    chk("abort:reached10", got, 1);
    bus.Abort = 1'b1;
    @(negedge Pulse);
    bus.Abort = 1'b0;
    chk("abort:timeset", bus.Timeset, 0);
    chk("abort:busy", bus.Busy, 0);
    chk("abort:minadv", bus.Minadv, 0);
    chk("abort:done", bus.Done, 0);
    chk("abort:err", bus.Err, 0);
    chk("abort:cur_min", c_min, 10);
    run_valid("resume", 1, 1, 0, 0, 30);

    // Start while Busy with an invalid target must be ignored.
    set_clock(1, 1, 0, 0, 0);
    clear_counts();
    do_start(1, 1, 0, 0, 20);
    repeat (6) @(negedge Pulse);
    chk("busy_start:busy", bus.Busy, 1);
    do_start(1, 1, 0, 0, 60);
    seen_done = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge Pulse);
      if (bus.Done === 1'b1) begin seen_done = 1; break; end
    end
    chk("busy_start:done", seen_done, 1);
    chk("busy_start:cur_min", c_min, 20);
    chk("busy_start:err", bus.Err, 0);

    // Asynchronous reset while a strobe is high.
    set_clock(1, 1, 0, 0, 0);
    do_start(1, 1, 0, 0, 5);
    got = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (bus.Minadv === 1'b1) begin got = 1; break; end
      @(negedge Pulse);
    end
    chk("reset_adv:reached", got, 1);
    #2 Reset = 1'b1;
    #1;
    chk("reset_adv:minadv", bus.Minadv, 0);
    chk("reset_adv:timeset", bus.Timeset, 0);
    chk("reset_adv:busy", bus.Busy, 0);
    @(negedge Pulse);
    Reset = 1'b0;
    repeat (2) @(negedge Pulse);
    chk("reset_adv:idle", bus.Busy, 0);

    for (int i = 0; i < 10; i++) begin
      mo = int'($urandom_range(1, NM));
      da = int'($urandom_range(1, mdays(mo)));
      set_clock(mo, da, int'($urandom_range(0, ND - 1)), int'($urandom_range(0, NH - 1)),
                int'($urandom_range(0, NS - 1)));
      mo = int'($urandom_range(1, NM));
      da = int'($urandom_range(1, mdays(mo)));
      run_valid("rnd", mo, da, int'($urandom_range(0, ND - 1)), int'($urandom_range(0, NH - 1)),
                int'($urandom_range(0, NS - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
